// File: rtl/afifo_rd_sched.sv
// afifo_rd_sched: read-side scheduler for the 32x8 asynchronous FIFO.
// Runs entirely in the read-clock domain. It shares the single FIFO read port
// among N consumers using round-robin arbitration. Once a consumer is granted,
// it keeps the grant for a burst of up to BURST words.
//
// Each word passes through the states ISSUE -> CAPT -> HOLD:
//   ISSUE  read strobe to the FIFO
//   CAPT   capture the registered FIFO output
//   HOLD   valid/ready handshake with the granted consumer
// Only one FIFO read is ever in flight at a time.
//
// Ports
//   r_clk         read-domain clock, posedge
//   w_rst         synchronous active-high reset
//   i_fifo_empty  FIFO empty flag (registered in r_clk domain)
//   i_fifo_dout   FIFO read data, valid the cycle after o_fifo_r_en
//   o_fifo_r_en   FIFO read enable, one-cycle pulse per word
//   i_req         per-consumer request level
//   i_out_ready   per-consumer ready
//   o_gnt         one-hot grant, held for the whole burst
//   o_out_valid   one-hot data valid, always a subset of o_gnt
//   o_out_data    delivered word (registered)
//   o_busy        high whenever the scheduler is not idle
module afifo_rd_sched #(
  parameter int unsigned W     = 8,
  parameter int unsigned N     = 4,
  parameter int unsigned BURST = 4
) (
  input  logic         r_clk,
  input  logic         w_rst,
  input  logic         i_fifo_empty,
  input  logic [W-1:0] i_fifo_dout,
  output logic         o_fifo_r_en,
  input  logic [N-1:0] i_req,
  input  logic [N-1:0] i_out_ready,
  output logic [N-1:0] o_gnt,
  output logic [N-1:0] o_out_valid,
  output logic [W-1:0] o_out_data,
  output logic         o_busy
);

  localparam int unsigned PW  = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned BCW = (BURST > 1) ? $clog2(BURST) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StCapt, StHold} state_e;

  state_e         r_state, w_state_d;
  logic [N-1:0]   r_gnt, w_gnt_d;
  logic [PW-1:0]  r_gidx, w_gidx_d;
  logic [PW-1:0]  r_rr_ptr, w_rr_ptr_d;
  logic [BCW-1:0] r_beat_cnt, w_beat_cnt_d;
  logic [N-1:0]   r_out_valid, w_out_valid_d;
  logic [W-1:0]   r_out_data, w_out_data_d;
  logic           r_fifo_r_en, w_fifo_r_en_d;

  logic           w_pick_vld;
  logic [PW-1:0]  w_pick_idx;
  logic [PW-1:0]  w_scan_idx;
  logic           w_burst_end;
  logic [PW-1:0]  w_rr_next;

  // Round-robin pick: first requester at or after r_rr_ptr, wrapping mod N.
  always_comb begin
    w_pick_vld = 1'b0;
    w_pick_idx = '0;
    w_scan_idx = '0;
    for (int k = 0; k < int'(N); k++) begin
      w_scan_idx = PW'((int'(r_rr_ptr) + k) % int'(N));
      if (!w_pick_vld && i_req[w_scan_idx]) begin
        w_pick_vld = 1'b1;
        w_pick_idx = w_scan_idx;
      end
    end
  end

  // Checked only at HOLD exit; the FIFO's empty flag has settled by then
  // because the last read strobe is at least two cycles old.
  assign w_burst_end = (r_beat_cnt == BCW'(BURST - 1)) || !i_req[r_gidx] || i_fifo_empty;
  assign w_rr_next   = (r_gidx == PW'(N - 1)) ? '0 : r_gidx + 1'b1;

  always_comb begin
    w_state_d     = r_state;
    w_gnt_d       = r_gnt;
    w_gidx_d      = r_gidx;
    w_rr_ptr_d    = r_rr_ptr;
    w_beat_cnt_d  = r_beat_cnt;
    w_out_valid_d = r_out_valid;
    w_out_data_d  = r_out_data;
    w_fifo_r_en_d = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_pick_vld && !i_fifo_empty) begin
          w_state_d     = StIssue;
          w_gnt_d       = N'(1) << w_pick_idx;
          w_gidx_d      = w_pick_idx;
          w_fifo_r_en_d = 1'b1;
        end
      end
      StIssue: w_state_d = StCapt;
      StCapt: begin
        w_out_data_d  = i_fifo_dout;
        w_out_valid_d = r_gnt;
        w_state_d     = StHold;
      end
      StHold: begin
        if (i_out_ready[r_gidx]) begin
          w_out_valid_d = '0;
          if (w_burst_end) begin
            w_state_d    = StIdle;
            w_gnt_d      = '0;
            w_rr_ptr_d   = w_rr_next;
            w_beat_cnt_d = '0;
          end else begin
            w_state_d     = StIssue;
            w_beat_cnt_d  = r_beat_cnt + 1'b1;
            w_fifo_r_en_d = 1'b1;
          end
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge r_clk) begin
    if (w_rst) begin
      r_state     <= StIdle;
      r_gnt       <= '0;
      r_gidx      <= '0;
      r_rr_ptr    <= '0;
      r_beat_cnt  <= '0;
      r_out_valid <= '0;
      r_out_data  <= '0;
      r_fifo_r_en <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_gnt       <= w_gnt_d;
      r_gidx      <= w_gidx_d;
      r_rr_ptr    <= w_rr_ptr_d;
      r_beat_cnt  <= w_beat_cnt_d;
      r_out_valid <= w_out_valid_d;
      r_out_data  <= w_out_data_d;
      r_fifo_r_en <= w_fifo_r_en_d;
    end
  end

  assign o_gnt       = r_gnt;
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_fifo_r_en = r_fifo_r_en;
  assign o_busy      = (r_state != StIdle);

endmodule

// File: tb/tb_afifo_rd_sched.sv
// Testbench for afifo_rd_sched: behavioural registered FIFO model plus a
// scoreboard of expected (consumer, word) deliveries.
module tb_afifo_rd_sched;
  localparam int N = 4;

  logic       r_clk = 1'b0;
  logic       w_rst = 1'b1;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_dout = 8'h00;
  logic       fifo_r_en;
  logic [3:0] req = '0;
  logic [3:0] out_ready = '0;
  logic [3:0] gnt;
  logic [3:0] out_valid;
  logic [7:0] out_data;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int ren_cnt = 0;
  logic [7:0] mq[$];
  int exp_q[$];
  int gnt_log[$];
  logic [3:0] prev_gnt = '0;

  afifo_rd_sched #(.W(8), .N(4), .BURST(4)) dut (
    .r_clk        (r_clk),
    .w_rst        (w_rst),
    .i_fifo_empty (fifo_empty),
    .i_fifo_dout  (fifo_dout),
    .o_fifo_r_en  (fifo_r_en),
    .i_req        (req),
    .i_out_ready  (out_ready),
    .o_gnt        (gnt),
    .o_out_valid  (out_valid),
    .o_out_data   (out_data),
    .o_busy       (busy)
  );

  always #5 r_clk = ~r_clk;

  // FIFO model: registered data and registered empty flag.
  always @(posedge r_clk) begin
    if (fifo_r_en) begin
      ren_cnt++;
      checks++;
      if (mq.size() == 0) begin
        errors++;
        $display("FAIL read_while_empty got r_en=1 exp r_en=0 with FIFO empty");
      end else begin
        fifo_dout <= mq.pop_front();
      end
    end
    fifo_empty <= (mq.size() == 0);
  end

  // Scoreboard and invariants, sampled away from the active edge.
  always @(negedge r_clk) begin
    if (!w_rst) begin
      checks++;
      if (((out_valid & ~gnt) != 4'b0) || !$onehot0(gnt)) begin
        errors++;
        $display("FAIL onehot_subset got gnt=%b valid=%b exp onehot0 gnt, valid within gnt",
                 gnt, out_valid);
      end
      for (int i = 0; i < N; i++) begin
        if (out_valid[i] && out_ready[i]) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL xfer_unexpected got cons=%0d data=%02h exp none", i, out_data);
          end else begin
            int e;
            e = exp_q.pop_front();
            if ((i * 256 + int'(out_data)) !== e) begin
              errors++;
              $display("FAIL xfer got cons=%0d data=%02h exp cons=%0d data=%02h",
                       i, out_data, e / 256, e % 256);
            end
          end
        end
      end
    end
    if (gnt != 4'b0 && prev_gnt == 4'b0)
      for (int i = 0; i < N; i++) if (gnt[i]) gnt_log.push_back(i);
    prev_gnt = gnt;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge r_clk);
    #1;
  endtask

  task automatic do_reset();
    req = '0;
    out_ready = '0;
    w_rst = 1'b1;
    cyc(2);
    w_rst = 1'b0;
  endtask

  task automatic fill(input int n, input int base, input int cons_div, input int cons_fix);
    for (int i = 0; i < n; i++) begin
      mq.push_back(8'(base + i));
      exp_q.push_back(((cons_div > 0) ? (i / cons_div) : cons_fix) * 256 + ((base + i) & 255));
    end
  endtask

  task automatic wait_drain(input int budget);
    for (int c = 0; c < budget && exp_q.size() != 0; c++) cyc(1);
    cyc(3);
  endtask

  task automatic test_reset();
    w_rst = 1'b1;
    req = 4'b1111;
    cyc(2);
    checks++;
    if ({gnt, out_valid, fifo_r_en, out_data, busy} !== 18'b0) begin
      errors++;
      $display("FAIL reset_outputs got gnt=%b valid=%b ren=%b data=%02h busy=%b exp all 0",
               gnt, out_valid, fifo_r_en, out_data, busy);
    end
    do_reset();
  endtask

  task automatic test_single_burst();
    int r0;
    r0 = ren_cnt;
    gnt_log.delete();
    fill(5, 8'h11, 0, 0);
    mq[1] = 8'h22; mq[2] = 8'h33; mq[3] = 8'h44; mq[4] = 8'h55;
    exp_q.delete();
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    exp_q.push_back(8'h44); exp_q.push_back(8'h55);
    out_ready = 4'b1111;
    req = 4'b0001;
    wait_drain(200);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL single_drain got %0d left exp 0", exp_q.size());
    end
    checks++;
    if (ren_cnt - r0 != 5) begin
      errors++;
      $display("FAIL single_ren got %0d exp 5", ren_cnt - r0);
    end
    checks++;
    if (gnt_log.size() != 2 || gnt_log[0] != 0 || gnt_log[1] != 0) begin
      errors++;
      $display("FAIL single_bursts got %0d grants exp 2 grants to consumer 0", gnt_log.size());
    end
    req = '0;
    cyc(3);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL single_idle got busy=%b exp 0", busy);
    end
  endtask

  task automatic test_round_robin();
    int r0;
    do_reset();
    r0 = ren_cnt;
    gnt_log.delete();
    fill(16, 8'h80, 4, 0);
    out_ready = 4'b1111;
    req = 4'b1111;
    wait_drain(400);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL rr_drain got %0d left exp 0", exp_q.size());
    end
    checks++;
    if (ren_cnt - r0 != 16) begin
      errors++;
      $display("FAIL rr_ren got %0d exp 16", ren_cnt - r0);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (gnt_log.size() <= i || gnt_log[i] != i) begin
        errors++;
        $display("FAIL rr_order got %0d exp %0d at grant %0d",
                 (gnt_log.size() > i) ? gnt_log[i] : -1, i, i);
      end
    end
    req = '0;
    cyc(2);
  endtask

  task automatic test_empty_end();
    int r0;
    do_reset();
    r0 = ren_cnt;
    fill(2, 8'hA1, 0, 2);
    out_ready = 4'b1111;
    req = 4'b0100;
    wait_drain(100);
    cyc(5);
    checks++;
    if (exp_q.size() != 0 || ren_cnt - r0 != 2) begin
      errors++;
      $display("FAIL empty_end got left=%0d ren=%0d exp left=0 ren=2", exp_q.size(), ren_cnt - r0);
    end
    checks++;
    if (busy !== 1'b0 || gnt !== 4'b0) begin
      errors++;
      $display("FAIL empty_idle got busy=%b gnt=%b exp 0 0000", busy, gnt);
    end
    req = '0;
  endtask

  task automatic test_stall();
    int r0;
    do_reset();
    fill(2, 8'hB1, 0, 1);
    out_ready = 4'b1101;
    req = 4'b0010;
    for (int c = 0; c < 50 && !out_valid[1]; c++) @(negedge r_clk);
    checks++;
    if (!out_valid[1]) begin
      errors++;
      $display("FAIL stall_valid got valid=%b exp 0010 within 50 cycles", out_valid);
    end
    r0 = ren_cnt;
    for (int c = 0; c < 10; c++) begin
      @(negedge r_clk);
      checks++;
      if (out_valid !== 4'b0010 || out_data !== 8'hB1) begin
        errors++;
        $display("FAIL stall_hold got valid=%b data=%02h exp 0010 b1", out_valid, out_data);
      end
    end
    checks++;
    if (ren_cnt != r0) begin
      errors++;
      $display("FAIL stall_ren got %0d exp 0 extra reads", ren_cnt - r0);
    end
    @(posedge r_clk); #1;
    out_ready = 4'b1111;
    wait_drain(100);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL stall_drain got %0d left exp 0", exp_q.size());
    end
    req = '0;
  endtask

  task automatic test_req_drop();
    int r0;
    do_reset();
    r0 = ren_cnt;
    mq.push_back(8'hC1); mq.push_back(8'hC2); mq.push_back(8'hC3);
    exp_q.push_back(3 * 256 + 8'hC1);
    out_ready = 4'b0111;
    req = 4'b1000;
    for (int c = 0; c < 50 && !out_valid[3]; c++) @(negedge r_clk);
    @(posedge r_clk); #1;
    req = 4'b0000;
    out_ready = 4'b1111;
    wait_drain(50);
    checks++;
    if (exp_q.size() != 0 || ren_cnt - r0 != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL drop_end got left=%0d ren=%0d busy=%b exp 0 1 0",
               exp_q.size(), ren_cnt - r0, busy);
    end
    gnt_log.delete();
    exp_q.push_back(8'hC2); exp_q.push_back(8'hC3);
    req = 4'b1001;
    wait_drain(100);
    checks++;
    if (gnt_log.size() < 1 || gnt_log[0] != 0) begin
      errors++;
      $display("FAIL drop_rrptr got %0d exp 0", (gnt_log.size() > 0) ? gnt_log[0] : -1);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drop_drain got %0d left exp 0", exp_q.size());
    end
    req = '0;
    cyc(2);
  endtask

  task automatic test_reset_mid();
    gnt_log.delete();
    mq.push_back(8'hD1); mq.push_back(8'hD2);
    out_ready = 4'b1111;
    req = 4'b0100;
    for (int c = 0; c < 50 && !fifo_r_en; c++) @(negedge r_clk);
    @(posedge r_clk); #1;
    w_rst = 1'b1;
    @(posedge r_clk); #1;
    checks++;
    if (gnt !== 4'b0 || out_valid !== 4'b0 || busy !== 1'b0 || fifo_r_en !== 1'b0) begin
      errors++;
      $display("FAIL midrst got gnt=%b valid=%b busy=%b ren=%b exp 0000 0000 0 0",
               gnt, out_valid, busy, fifo_r_en);
    end
    checks++;
    if (gnt_log.size() < 1 || gnt_log[0] != 2) begin
      errors++;
      $display("FAIL midrst_first got %0d exp 2", (gnt_log.size() > 0) ? gnt_log[0] : -1);
    end
    req = '0;
    w_rst = 1'b0;
    cyc(1);
    exp_q.push_back(8'hD2);
    req = 4'b0101;
    wait_drain(100);
    checks++;
    if (gnt_log.size() != 2 || gnt_log[1] != 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL midrst_rr got grants=%0d last=%0d left=%0d exp 2 0 0", gnt_log.size(),
               (gnt_log.size() > 0) ? gnt_log[gnt_log.size() - 1] : -1, exp_q.size());
    end
    req = '0;
  endtask

  initial begin
    #1;
    test_reset();
    test_single_burst();
    test_round_robin();
    test_empty_end();
    test_stall();
    test_req_drop();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1);
  end

endmodule
